// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter with inhibit, ack check and timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, RELEASE, SEND, ACK, WAIT_IDLE} state_t;
  state_t state;
  logic [1:0] clk_sync, data_sync;
  logic clk_d;
  logic [9:0] shift_reg;
  logic [3:0] bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic sync_clk, sync_data, fe, timed, to_hit;
  assign sync_clk  = clk_sync[1];
  assign sync_data = data_sync[1];
  assign fe        = clk_d & ~sync_clk;
  assign timed     = state inside {RELEASE, SEND, ACK, WAIT_IDLE};
  assign to_hit    = timed && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_sync    <= 2'b11;
      data_sync   <= 2'b11;
      clk_d       <= 1'b1;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[0], ps2_clk_in};
      data_sync   <= {data_sync[0], ps2_data_in};
      clk_d       <= sync_clk;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      if (timed) to_cnt <= to_cnt + 1'b1;
      // timeout wins over any same-cycle edge or ack
      if (to_hit) begin
        state       <= IDLE;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
              shift_reg  <= {1'b1, ~^tx_data, tx_data};
              bit_cnt    <= '0;
              inh_cnt    <= '0;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else inh_cnt <= inh_cnt + 1'b1;
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            state      <= RELEASE;
          end
          RELEASE: begin
            if (fe) begin
              ps2_data_oe <= ~shift_reg[0];
              state       <= SEND;
            end
          end
          SEND: begin
            if (fe) begin
              shift_reg   <= {1'b0, shift_reg[9:1]};
              bit_cnt     <= bit_cnt + 1'b1;
              ps2_data_oe <= ~shift_reg[1];
              if (bit_cnt == 4'd8) state <= ACK;
            end
          end
          ACK: begin
            if (fe) begin
              state <= sync_data ? IDLE : WAIT_IDLE;
              busy  <= ~sync_data;
              ack_err <= sync_data;
            end
          end
          WAIT_IDLE: begin
            if (sync_clk && sync_data) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 host transmitter bench with a behavioural keyboard model.
module tb_ps2_host_tx;
  localparam int INH = 40, TO = 2000, HALF = 20, BOUND = 4000;
  logic clk = 0, rst = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic dev_clk_low = 0, dev_data_low = 0;
  logic clk_line, data_line;
  int errors = 0, checks = 0;
  int inh_m = 0, n_done = 0, n_ack = 0, n_to = 0, n_starts = 0;
  logic oe_prev = 0;

  assign clk_line  = !(ps2_clk_oe || dev_clk_low);
  assign data_line = !(ps2_data_oe || dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_err(ack_err),
    .timeout_err(timeout_err)
  );

  always @(negedge clk) begin
    if (ps2_clk_oe && !ps2_data_oe) inh_m++;
    if (done) n_done++;
    if (ack_err) n_ack++;
    if (timeout_err) n_to++;
    if (ps2_clk_oe && !oe_prev) n_starts++;
    oe_prev = ps2_clk_oe;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // expected line bits in order: start, d0..d7, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, ones % 2 == 0, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!tx_ready && n < BOUND) begin @(negedge clk); n++; end
    ok = tx_ready;
  endtask

  task automatic wait_rts(output bit ok);
    int n = 0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && n < BOUND) begin @(negedge clk); n++; end
    ok = (n < BOUND);
  endtask

  task automatic send_req(input logic [7:0] b);
    @(negedge clk);
    tx_data = b; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic dev_clock(output logic s);
    dev_clk_low = 1; wait_cyc(HALF);
    dev_clk_low = 0; s = data_line; wait_cyc(HALF);
  endtask

  task automatic device_rx(input bit do_ack, output logic [10:0] bits, output bit ok);
    logic s;
    bits = '0;
    wait_rts(ok);
    if (!ok) return;
    wait_cyc(HALF);
    bits[0] = data_line;
    for (int i = 1; i <= 10; i++) begin dev_clock(s); bits[i] = s; end
    dev_data_low = do_ack; wait_cyc(HALF);
    dev_clock(s);
    dev_data_low = 0;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack, output logic [10:0] bits, output bit ok);
    bit r1, r2, r3;
    wait_ready(r1);
    send_req(b);
    device_rx(ack, bits, r2);
    wait_ready(r3);
    wait_cyc(3);
    ok = r1 && r2 && r3;
  endtask

  task automatic test_reset;
    wait_cyc(3);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err} !== 7'b1000000) begin
      errors++; $display("FAIL reset_state: got %b expected 1000000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err});
    end
    rst = 0;
    wait_cyc(3);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
      errors++; $display("FAIL post_reset: got %b expected 1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_ed;
    logic [10:0] bits, exp;
    bit ok;
    int i0 = inh_m, d0 = n_done, a0 = n_ack;
    exp = frame_of(8'hED);
    do_frame(8'hED, 1, bits, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ed_handshake: got 0 expected 1"); end
    checks++; if (bits !== exp) begin errors++; $display("FAIL ed_frame: got %b expected %b", bits, exp); end
    checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL ed_parity: got %b expected 1", bits[9]); end
    checks++; if (inh_m - i0 !== INH) begin errors++; $display("FAIL ed_inhibit: got %0d expected %0d", inh_m - i0, INH); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL ed_done: got %0d expected 1", n_done - d0); end
    checks++; if (n_ack - a0 !== 0) begin errors++; $display("FAIL ed_ack_err: got %0d expected 0", n_ack - a0); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ed_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_parity;
    logic [7:0] pats [7];
    logic [10:0] bits, exp;
    bit ok;
    int d0;
    pats = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 3; k < 7; k++) pats[k] = 8'($urandom);
    foreach (pats[k]) begin
      d0 = n_done;
      exp = frame_of(pats[k]);
      do_frame(pats[k], 1, bits, ok);
      checks++; if (!ok || bits !== exp) begin errors++; $display("FAIL parity_frame %h: got %b expected %b", pats[k], bits, exp); end
      checks++; if (^bits[9:1] !== 1'b1) begin errors++; $display("FAIL parity_odd %h: got %b expected odd", pats[k], bits[9:1]); end
      checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL parity_done %h: got %0d expected 1", pats[k], n_done - d0); end
    end
  endtask

  task automatic test_no_ack;
    logic [7:0] b = 8'($urandom);
    logic [10:0] bits;
    bit ok;
    int d0 = n_done, a0 = n_ack;
    do_frame(b, 0, bits, ok);
    checks++; if (n_ack - a0 !== 1) begin errors++; $display("FAIL noack_err: got %0d expected 1", n_ack - a0); end
    checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL noack_done: got %0d expected 0", n_done - d0); end
    checks++; if ({ok, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
      errors++; $display("FAIL noack_idle: got %b expected 1000", {ok, busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int t = 0, d0 = n_done, e0 = n_to;
    wait_ready(ok);
    send_req(8'($urandom));
    wait_rts(ok);
    while (!timeout_err && t < TO + 100) begin @(negedge clk); t++; end
    checks++; if (!ok || t !== TO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", t, TO); end
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
    wait_ready(ok);
    wait_cyc(3);
    checks++; if (n_to - e0 !== 1 || n_done - d0 !== 0) begin
      errors++; $display("FAIL timeout_pulses: got to=%0d done=%0d expected to=1 done=0", n_to - e0, n_done - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] exp, bits;
    logic s;
    bit ok;
    int d0;
    exp = frame_of(8'h55);
    wait_ready(ok);
    send_req(8'h55);
    wait_rts(ok);
    wait_cyc(HALF);
    for (int i = 0; i < 4; i++) dev_clock(s);
    checks++; if ({busy, ps2_data_oe} !== {1'b1, !exp[4]}) begin
      errors++; $display("FAIL mid_send_d3: got %b expected %b", {busy, ps2_data_oe}, {1'b1, !exp[4]});
    end
    rst = 1;
    #1;
    checks++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      errors++; $display("FAIL mid_async_release: got %b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
    wait_cyc(2);
    rst = 0;
    wait_cyc(2);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", tx_ready); end
    d0 = n_done;
    exp = frame_of(8'hF4);
    do_frame(8'hF4, 1, bits, ok);
    checks++; if (!ok || bits !== exp || n_done - d0 !== 1) begin
      errors++; $display("FAIL mid_f4: got %b done=%0d expected %b done=1", bits, n_done - d0, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1 = 8'($urandom), b2 = 8'($urandom);
    logic [10:0] bits1, bits2, e1, e2;
    bit ok1, ok2, r;
    int s0, d0;
    e1 = frame_of(b1);
    e2 = frame_of(b2);
    wait_ready(r);
    s0 = n_starts; d0 = n_done;
    @(negedge clk);
    tx_data = b1; tx_valid = 1;
    @(negedge clk);
    tx_data = b2;
    device_rx(1, bits1, ok1);
    wait_ready(r);
    @(negedge clk);
    checks++; if ({r, ps2_clk_oe, tx_ready} !== 3'b110) begin
      errors++; $display("FAIL b2b_restart: got %b expected 110", {r, ps2_clk_oe, tx_ready});
    end
    tx_valid = 0;
    device_rx(1, bits2, ok2);
    wait_ready(r);
    wait_cyc(INH + 10);
    checks++; if (!ok1 || !ok2 || bits1 !== e1 || bits2 !== e2) begin
      errors++; $display("FAIL b2b_frames: got %b %b expected %b %b", bits1, bits2, e1, e2);
    end
    checks++; if (n_starts - s0 !== 2 || n_done - d0 !== 2) begin
      errors++; $display("FAIL b2b_count: got starts=%0d done=%0d expected 2 2", n_starts - s0, n_done - d0);
    end
  endtask

  initial begin
    test_reset;
    test_ed;
    test_parity;
    test_no_ack;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
